// File: rtl/alu_sequencer.sv
// ============================================================================
//  Module      : alu_sequencer
//  Description : Four-phase (IDLE/READ/EXEC/WRITE) instruction sequencer
//                around an external combinational ALU, with a 2**AW x NBIT
//                register file (register 0 hard-wired to zero) and a
//                combinational debug read port.
//  Options     : define ALU_SEQ_ZFLAG_EN to build the zero-status flop;
//                otherwise z_flag is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int NBIT = 16,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_fs,
    input  logic [AW-1:0]   instr_ra,
    input  logic [AW-1:0]   instr_rb,
    input  logic [AW-1:0]   instr_rd,
    output logic [NBIT-1:0] alu_a,
    output logic [NBIT-1:0] alu_b,
    output logic [3:0]      alu_fs,
    input  logic [NBIT-1:0] alu_result,
    output logic            done,
    output logic            z_flag,
    input  logic [AW-1:0]   dbg_addr,
    output logic [NBIT-1:0] dbg_data
);

    localparam int NREG = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_ready;
    logic            w_done;
    logic            w_accept;
    logic            w_nowrite;
    logic            w_wr_en;

    logic [3:0]      r_fs;
    logic [AW-1:0]   r_ra;
    logic [AW-1:0]   r_rb;
    logic [AW-1:0]   r_rd;
    logic [NBIT-1:0] r_alu_a;
    logic [NBIT-1:0] r_alu_b;
    logic [3:0]      r_alu_fs;
    logic [NBIT-1:0] r_result;
    logic [NBIT-1:0] r_regs [NREG];

    logic [NBIT-1:0] w_rd_a;
    logic [NBIT-1:0] w_rd_b;

    assign w_accept = instr_valid && w_ready;

    // Function codes whose result must not be committed (compare/test style ops).
    assign w_nowrite = (r_fs == 4'b1000) || (r_fs == 4'b1001) || (r_fs == 4'b1010) ||
                       (r_fs == 4'b1101) || (r_fs == 4'b1110);

    // Register 0 is never written, so skip the write entirely when rd is 0.
    assign w_wr_en = (r_state == S_WRITE) && !w_nowrite && (r_rd != '0);

    // Register-file reads; register 0 always reads as zero.
    assign w_rd_a   = (r_ra == '0)     ? '0 : r_regs[r_ra];
    assign w_rd_b   = (r_rb == '0)     ? '0 : r_regs[r_rb];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

    assign instr_ready = w_ready;
    assign done        = w_done;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_fs      = r_alu_fs;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus handshake/retire outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Instruction capture, operand fetch and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_fs <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_fs <= instr_fs;
                r_ra <= instr_ra;
                r_rb <= instr_rb;
                r_rd <= instr_rd;
            end
            if (r_state == S_READ) begin
                r_alu_a  <= w_rd_a;
                r_alu_b  <= w_rd_b;
                r_alu_fs <= r_fs;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    // Register file: commit at the end of WRITE, so same-cycle debug reads see the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[r_rd] <= r_result;
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    logic r_z;

    // Zero status follows every committing instruction, including rd = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= 1'b0;
        end else if ((r_state == S_WRITE) && !w_nowrite) begin
            r_z <= (r_result == '0);
        end
    end

    assign z_flag = r_z;
`else
    assign z_flag = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none

module tb_alu_sequencer;

`ifdef ALU_SEQ_ZFLAG_EN
    localparam logic ZEN = 1'b1;
`else
    localparam logic ZEN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_fs;
    logic [2:0]  instr_ra, instr_rb, instr_rd;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fs;
    logic [15:0] alu_result;
    logic        done;
    logic        z_flag;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] tb_imm;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    alu_sequencer #(.NBIT(16), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_fs(instr_fs), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rd(instr_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs), .alu_result(alu_result),
        .done(done), .z_flag(z_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU used by the bench (1011 loads an immediate supplied by the bench).
    function automatic logic [15:0] alu_fn(input logic [3:0] fs, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] imm);
        case (fs)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return ~a;
            4'b0110: return a << 1;
            4'b0111: return a >> 1;
            4'b1011: return imm;
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_fs, alu_a, alu_b, tb_imm);

    function automatic logic is_nowrite(input logic [3:0] fs);
        return (fs == 4'd8) || (fs == 4'd9) || (fs == 4'd10) || (fs == 4'd13) || (fs == 4'd14);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An accepted instruction occupies the next three cycles; operands become
    // visible from its 2nd cycle, done marks its 3rd, and the commit lands at
    // the end of that cycle.
    logic        m_busy;
    int          m_age;
    logic [3:0]  m_ifs;
    logic [2:0]  m_ira, m_irb, m_ird;
    logic [15:0] m_a, m_b, m_res;
    logic [3:0]  m_fs;
    logic        m_z;
    logic [15:0] m_regs [8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_fs   <= '0;
            m_res  <= '0;
            m_z    <= 1'b0;
            for (int i = 0; i < 8; i++) m_regs[i] <= '0;
        end else if (!m_busy) begin
            if (instr_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_ifs  <= instr_fs;
                m_ira  <= instr_ra;
                m_irb  <= instr_rb;
                m_ird  <= instr_rd;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age == 1) begin
                m_a  <= m_regs[m_ira];
                m_b  <= m_regs[m_irb];
                m_fs <= m_ifs;
            end
            if (m_age == 2) m_res <= alu_fn(m_fs, m_a, m_b, tb_imm);
            if (m_age == 3) begin
                m_busy <= 1'b0;
                if (!is_nowrite(m_ifs)) begin
                    if (m_ird != 3'd0) m_regs[m_ird] <= m_res;
                    if (ZEN) m_z <= (m_res == 16'd0);
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",  {31'd0, instr_ready}, {31'd0, !m_busy});
            chk("done",   {31'd0, done},        {31'd0, (m_busy && m_age == 3)});
            chk("alu_a",  {16'd0, alu_a},       {16'd0, m_a});
            chk("alu_b",  {16'd0, alu_b},       {16'd0, m_b});
            chk("alu_fs", {28'd0, alu_fs},      {28'd0, m_fs});
            chk("z_flag", {31'd0, z_flag},      {31'd0, m_z});
            chk("dbg",    {16'd0, dbg_data},    {16'd0, m_regs[dbg_addr]});
        end
    end

    // Issue one instruction and report the cycle (accept cycle = 0) where done was seen.
    task automatic issue(input logic [3:0] fs, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic [15:0] imm, output int lat);
        int n;
        n = 0;
        while (!instr_ready && n < 16) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 16) begin
            n_tests++; n_fail++;
            $display("FAIL ready_wait: got ready=0 after %0d cycles expected ready=1", n);
        end
        instr_fs = fs; instr_ra = ra; instr_rb = rb; instr_rd = rd;
        tb_imm = imm; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge clk); #1; lat++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int rdy_cnt;
        instr_valid = 1'b0; instr_fs = '0; instr_ra = '0; instr_rb = '0; instr_rd = '0;
        dbg_addr = '0; tb_imm = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload and add.
        issue(4'b1011, 3'd0, 3'd0, 3'd1, 16'd5, lat);
        issue(4'b1011, 3'd0, 3'd0, 3'd2, 16'd3, lat);
        issue(4'b0000, 3'd1, 3'd2, 3'd3, 16'd0, lat);
        chk("add_latency", lat, 32'd3);
        dbg_addr = 3'd3; #1;
        chk("add_r3", {16'd0, dbg_data}, 32'd8);
        chk("add_z",  {31'd0, z_flag}, 32'd0);

        // Subtract to zero.
        issue(4'b0001, 3'd1, 3'd1, 3'd4, 16'd0, lat);
        dbg_addr = 3'd4; #1;
        chk("sub_r4", {16'd0, dbg_data}, 32'd0);
        chk("sub_z",  {31'd0, z_flag}, {31'd0, ZEN});

        // No-write code: r3 and z_flag untouched.
        issue(4'b1000, 3'd1, 3'd2, 3'd3, 16'd0, lat);
        chk("nowr_latency", lat, 32'd3);
        dbg_addr = 3'd3; #1;
        chk("nowr_r3", {16'd0, dbg_data}, 32'd8);
        chk("nowr_z",  {31'd0, z_flag}, {31'd0, ZEN});

        // rd = 0: discarded write, done still pulses, z follows result 8.
        issue(4'b0000, 3'd1, 3'd2, 3'd0, 16'd0, lat);
        chk("rd0_latency", lat, 32'd3);
        dbg_addr = 3'd0; #1;
        chk("rd0_r0", {16'd0, dbg_data}, 32'd0);
        chk("rd0_z",  {31'd0, z_flag}, 32'd0);

        // Continuous valid: one accept per four cycles.
        rdy_cnt = 0;
        tb_imm = 16'h00F0;
        instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (instr_ready) rdy_cnt++;
            instr_fs = 4'($urandom_range(0, 15));
            instr_ra = 3'($urandom); instr_rb = 3'($urandom); instr_rd = 3'($urandom);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        chk("stream_ready_cnt", rdy_cnt, 32'd4);

        // Dependent pair, back to back.
        issue(4'b1011, 3'd0, 3'd0, 3'd5, 16'd77, lat);
        issue(4'b1100, 3'd5, 3'd0, 3'd6, 16'd0, lat);
        chk("dep_alu_a", {16'd0, alu_a}, 32'd77);
        dbg_addr = 3'd6; #1;
        chk("dep_r6", {16'd0, dbg_data}, 32'd77);

        // Debug read racing the commit.
        issue(4'b1011, 3'd0, 3'd0, 3'd7, 16'h0AAA, lat);
        dbg_addr = 3'd7;
        instr_fs = 4'b1011; instr_rd = 3'd7; tb_imm = 16'h1234; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wr_cycle_done", {31'd0, done}, 32'd1);
        chk("wr_cycle_old",  {16'd0, dbg_data}, 32'h0AAA);
        @(posedge clk); #1;
        chk("wr_next_new",   {16'd0, dbg_data}, 32'h1234);

        // Reset during EXEC.
        instr_fs = 4'b0000; instr_ra = 3'd7; instr_rb = 3'd7; instr_rd = 3'd6; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #6;
        chk("rstx_done",  {31'd0, done}, 32'd0);
        chk("rstx_ready", {31'd0, instr_ready}, 32'd1);
        chk("rstx_alu_b", {16'd0, alu_b}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        dbg_addr = 3'd6;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rstx_no_done", {31'd0, done}, 32'd0);
        end
        chk("rstx_r6", {16'd0, dbg_data}, 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            instr_valid = ($urandom_range(0, 2) != 0);
            instr_fs = 4'($urandom_range(0, 15));
            instr_ra = 3'($urandom); instr_rb = 3'($urandom); instr_rd = 3'($urandom);
            dbg_addr = 3'($urandom);
            tb_imm   = 16'($urandom);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
